// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid stage.
//   state_t        : occupancy state of a stage (EMPTY / MAIN / SKID)
//   DEF_*_W        : default widths of ctrl, payload and stall counter
//   CTRL_*         : bit positions of the control fields inside ctrl
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_MAIN  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    localparam int unsigned DEF_CTRL_W  = 2;
    localparam int unsigned DEF_DATA_W  = 69;
    localparam int unsigned DEF_STALL_W = 16;

    localparam int unsigned CTRL_REGWRITE = 0;
    localparam int unsigned CTRL_MEMTOREG = 1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
//   clk   in   rising-edge clock
//   rst   in   asynchronous reset, clears the count
//   inc   in   add one this cycle (ignored once the count is all-ones)
//   count out  current count, STALL_W bits
module sat_counter
    import pipe_pkg::*;
#(
    parameter int unsigned STALL_W = DEF_STALL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    output logic [STALL_W-1:0] count
);

    logic [STALL_W-1:0] count_q;
    logic [STALL_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry
// skid buffer, so that in_ready is a flop and never depends on out_ready.
//   clk, rst           clock, asynchronous active-high reset
//   flush              synchronous kill of all held entries
//   in_valid/in_ready  upstream handshake (in_ready registered)
//   in_ctrl/in_data    upstream control bits and payload
//   out_valid/out_ready downstream handshake
//   out_ctrl/out_data  control bits (zero on bubble) and payload
//   stall_cnt          saturating count of cycles with out_valid && !out_ready
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W  = DEF_CTRL_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned STALL_W = DEF_STALL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CTRL_W-1:0]  in_ctrl,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [DATA_W-1:0]  out_data,
    output logic [STALL_W-1:0] stall_cnt
);

    state_t              state_q,     state_d;
    logic                in_ready_q,  in_ready_d;
    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;

    logic in_xfer;
    logic out_xfer;

    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = in_ready_q;
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;

    assign in_xfer  = in_valid && in_ready_q;
    assign out_xfer = out_valid && out_ready;

    // The main ctrl register is written with zero whenever the stage drains,
    // so out_ctrl needs no output gating to stay zero on a bubble.
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    main_ctrl_d = in_ctrl;
                    main_data_d = in_data;
                    state_d     = ST_MAIN;
                end
            end
            ST_MAIN: begin
                if (out_xfer && in_xfer) begin
                    main_ctrl_d = in_ctrl;
                    main_data_d = in_data;
                end else if (out_xfer) begin
                    main_ctrl_d = '0;
                    state_d     = ST_EMPTY;
                end else if (in_xfer) begin
                    skid_ctrl_d = in_ctrl;
                    skid_data_d = in_data;
                    state_d     = ST_SKID;
                end
            end
            ST_SKID: begin
                if (out_xfer) begin
                    main_ctrl_d = skid_ctrl_q;
                    main_data_d = skid_data_q;
                    skid_ctrl_d = '0;
                    state_d     = ST_MAIN;
                end
            end
            default: begin
                state_d     = ST_EMPTY;
                main_ctrl_d = '0;
                skid_ctrl_d = '0;
            end
        endcase

        // Flush wins over any transfer; payload is left stale on purpose.
        if (flush) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end

        in_ready_d = (state_d != ST_SKID);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

    sat_counter #(
        .STALL_W (STALL_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid && !out_ready),
        .count (stall_cnt)
    );

    // Upstream must hold an offered entry steady until it is accepted.
    property p_in_stable;
        @(posedge clk) disable iff (rst)
        (in_valid && !in_ready_q && !flush) |=>
            (in_valid && $stable(in_ctrl) && $stable(in_data));
    endproperty
    a_in_stable: assert property (p_in_stable);

endmodule

// File: tb/tb_pipe_skid_stage.sv
module tb_pipe_skid_stage;
    import pipe_pkg::*;

    localparam int CW = 2;
    localparam int DW = 69;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [SW-1:0] stall_cnt;

    logic          s_flush;
    logic          s_in_valid;
    logic          s_in_ready;
    logic          s_out_valid;
    logic          s_out_ready;
    logic [CW-1:0] s_out_ctrl;
    logic [DW-1:0] s_out_data;
    logic [3:0]    s_stall;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    pipe_skid_stage #(.CTRL_W(CW), .DATA_W(DW), .STALL_W(SW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    pipe_skid_stage #(.CTRL_W(CW), .DATA_W(DW), .STALL_W(4)) u_sat (
        .clk(clk), .rst(rst), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
        .stall_cnt(s_stall)
    );

    // Reference model: the stage is a FIFO of at most two entries.
    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } ent_t;

    ent_t        q[$];
    int unsigned m_stall   = 0;
    bit          m_blocked = 1'b0;

    always @(posedge clk or posedge rst) begin
        ent_t e;
        bit   acc;
        bit   pop;
        if (rst) begin
            q.delete();
            m_stall   = 0;
            m_blocked = 1'b0;
        end else begin
            acc = in_valid && (q.size() < 2);
            pop = (q.size() > 0) && out_ready;
            m_blocked = in_valid && !acc && !flush;
            if ((q.size() > 0) && !out_ready && (m_stall < 65535)) m_stall++;
            if (flush) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (acc) begin
                    e.ctrl = in_ctrl;
                    e.data = in_data;
                    q.push_back(e);
                end
            end
        end
    end

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_compare();
        bit mv;
        mv = (q.size() != 0);
        check("m_out_valid", 128'(out_valid), 128'(mv));
        check("m_in_ready", 128'(in_ready), 128'(q.size() < 2));
        check("m_out_ctrl", 128'(out_ctrl), mv ? 128'(q[0].ctrl) : 128'(0));
        if (mv) check("m_out_data", 128'(out_data), 128'(q[0].data));
        check("m_stall_cnt", 128'(stall_cnt), 128'(m_stall));
    endtask

    // One cycle: compare against the model on the falling edge, then move to
    // just after the next rising edge where stimulus is updated.
    task automatic step();
        @(negedge clk);
        if (!rst) model_compare();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit v, logic [CW-1:0] c, logic [DW-1:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
    endtask

    initial begin
        flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
        s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0;

        // Reset state
        step();
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_ctrl", 128'(out_ctrl), 128'(0));
        check("rst_out_data", 128'(out_data), 128'(0));
        check("rst_stall", 128'(stall_cnt), 128'(0));
        check("rst_sat_stall", 128'(s_stall), 128'(0));
        step();
        rst = 1'b0;
        out_ready = 1'b1;

        // Streaming 0..9, one cycle latency, no gaps
        drive(1'b1, 2'd0, 69'd0);
        for (int i = 1; i <= 10; i++) begin
            step();
            check("stream_valid", 128'(out_valid), 128'(1));
            check("stream_data", 128'(out_data), 128'(i - 1));
            check("stream_ready", 128'(in_ready), 128'(1));
            if (i < 10) drive(1'b1, CW'(i), DW'(i));
            else        drive(1'b0, 2'd0, 69'd0);
        end
        step();
        check("stream_drained", 128'(out_valid), 128'(0));
        check("stream_stall", 128'(stall_cnt), 128'(0));

        // Backpressure: A then B with out_ready low
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 69'h0A);
        step();
        check("bp_a_data", 128'(out_data), 128'(69'h0A));
        check("bp_a_ready", 128'(in_ready), 128'(1));
        check("bp_a_stall", 128'(stall_cnt), 128'(0));
        drive(1'b1, 2'b10, 69'h0B);
        step();
        check("bp_skid_ready", 128'(in_ready), 128'(0));
        check("bp_skid_data", 128'(out_data), 128'(69'h0A));
        check("bp_skid_stall", 128'(stall_cnt), 128'(1));
        drive(1'b0, 2'b00, 69'h0);
        step();
        check("bp_hold_data", 128'(out_data), 128'(69'h0A));
        check("bp_hold_stall", 128'(stall_cnt), 128'(2));
        out_ready = 1'b1;
        step();
        check("bp_b_data", 128'(out_data), 128'(69'h0B));
        check("bp_b_ctrl", 128'(out_ctrl), 128'(2'b10));
        check("bp_b_ready", 128'(in_ready), 128'(1));
        check("bp_b_stall", 128'(stall_cnt), 128'(2));
        step();
        check("bp_empty", 128'(out_valid), 128'(0));

        // Flush while in SKID with a coincident input
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 69'h0C);
        step();
        check("fl_c_data", 128'(out_data), 128'(69'h0C));
        drive(1'b1, 2'b01, 69'h0D);
        step();
        check("fl_skid_ready", 128'(in_ready), 128'(0));
        check("fl_skid_stall", 128'(stall_cnt), 128'(3));
        drive(1'b1, 2'b11, 69'h0E);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_out_valid", 128'(out_valid), 128'(0));
        check("fl_out_ctrl", 128'(out_ctrl), 128'(0));
        check("fl_in_ready", 128'(in_ready), 128'(1));
        check("fl_stall", 128'(stall_cnt), 128'(4));

        // Bubble: ctrl inputs high but nothing valid
        drive(1'b0, 2'b11, 69'h1F);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bub_valid", 128'(out_valid), 128'(0));
            check("bub_ctrl", 128'(out_ctrl), 128'(0));
        end

        // Reset asserted with two entries held
        out_ready = 1'b0;
        drive(1'b1, 2'b11, 69'h10);
        step();
        drive(1'b1, 2'b11, 69'h11);
        step();
        check("mr_pre_stall", 128'(stall_cnt), 128'(5));
        check("mr_pre_ready", 128'(in_ready), 128'(0));
        drive(1'b0, 2'b00, 69'h0);
        rst = 1'b1;
        #1;
        check("mr_out_valid", 128'(out_valid), 128'(0));
        check("mr_out_ctrl", 128'(out_ctrl), 128'(0));
        check("mr_in_ready", 128'(in_ready), 128'(1));
        check("mr_stall", 128'(stall_cnt), 128'(0));
        step();
        rst = 1'b0;
        out_ready = 1'b1;

        // Saturation on the 4-bit counter instance
        s_out_ready = 1'b0;
        s_in_valid  = 1'b1;
        step();
        s_in_valid  = 1'b0;
        check("sat_valid", 128'(s_out_valid), 128'(1));
        for (int i = 0; i < 5; i++) step();
        check("sat_5", 128'(s_stall), 128'(5));
        for (int i = 0; i < 15; i++) step();
        check("sat_20", 128'(s_stall), 128'(15));
        for (int i = 0; i < 5; i++) step();
        check("sat_hold", 128'(s_stall), 128'(15));

        // Random valid/ready/flush traffic against the model
        for (int i = 0; i < 10000; i++) begin
            step();
            if (!m_blocked) begin
                drive(($urandom % 10) < 7, CW'($urandom), DW'({$urandom, $urandom, $urandom}));
            end
            out_ready = ($urandom % 10) < 6;
            flush     = ($urandom % 50) == 0;
        end
        drive(1'b0, 2'b00, 69'h0);
        flush = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        step();
        check("end_drained", 128'(out_valid), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
